counter_checker: RTL and testbench
==================================

# counter_checker

Receive-side checker for the free-running binary counter pattern that fabric user designs drive onto their IO pins. It samples a parallel word every clock, locks onto an incrementing sequence, and then flags and counts every sample that breaks the sequence. It is instantiated in loopback and board-bring-up user designs to verify counter-pattern transmitters across the IO boundary.

## Interface
Parameters:
- WIDTH, 8, width of the sampled counter word (matches the transmitter's IO count).
- LOCK_N, 4, consecutive in-sequence samples required to enter LOCKED (≥1).
- UNLOCK_N, 3, consecutive out-of-sequence samples in LOCKED that force a return to SEARCH (≥1).
- ERRCNT_W, 16, width of the error counter.

Ports:
- clk  in  1  single clock; all state is on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of err_count; FSM is unaffected.
- din  in  WIDTH  sampled counter word.
- locked  out  1  high while the FSM is in LOCKED.
- err  out  1  one-cycle pulse per out-of-sequence sample while LOCKED.
- err_count  out  ERRCNT_W  saturating count of err pulses.
- expected  out  WIDTH  value predicted for the next sample.

## Operation
- Reset values: FSM = SEARCH; locked=0, err=0, err_count=0, expected=0; match and miss counters = 0.
- "Sample" means din after the optional synchronizer (see Configuration).
- Sequence arithmetic is modulo 2^WIDTH. expected = previous sample + 1, so all-ones followed by 0 is in sequence.
- SEARCH: capture the sample and set expected = sample+1 and match_cnt=0. Next state is VERIFY.
- VERIFY:
  - If sample == expected: match_cnt+1 and expected+1. When match_cnt reaches LOCK_N, go to LOCKED and clear miss_cnt.
  - If sample != expected: set expected = sample+1 and match_cnt=0. Stay in VERIFY. err does not pulse.
- LOCKED:
  - expected increments every cycle (flywheel), regardless of match or mismatch.
  - On a match: miss_cnt=0.
  - On a mismatch: err pulses, err_count+1 (saturates at all-ones), and miss_cnt+1.
  - When miss_cnt reaches UNLOCK_N, go to SEARCH. The Nth miss still pulses err and counts.
- clr and an error in the same cycle: err still pulses and err_count ends at 0 (clr wins).
- A transmitter held in reset (constant 0) never locks. Release of its reset produces normal lock after LOCK_N+1 samples.
- rst_n assertion at any time immediately forces all reset values (asynchronous). Deassertion must be synchronized to clk by the integrator.

## Timing
- All outputs are registered.
- A sample present before clk edge k is evaluated at edge k. err, err_count, locked and expected reflect it after edge k.
- Lock latency, without sync, from the first of an unbroken run: 1 SEARCH cycle + LOCK_N VERIFY cycles. locked rises after edge LOCK_N+1.
- Unlock: locked falls after the edge that evaluates the UNLOCK_N-th consecutive miss.
- err is never high for two cycles from a single bad sample.
- Back-to-back bad samples give back-to-back err pulses.

## Configuration
- COUNTER_CHECKER_SYNC_EN defined: din passes through a 2-flop synchronizer (reset to 0) before evaluation. Every latency above grows by 2 cycles. Use this for asynchronous or off-chip sources.
- Not defined: din is evaluated directly. The source must be synchronous to clk.

## Test plan
- Clean lock: WIDTH=8, LOCK_N=4, din=0,1,2,… from cycle 0 → locked=1 after edge 5, err never asserts, expected=din+1 each cycle.
- Wrap: locked, din …0xFE,0xFF,0x00,0x01 → no err, err_count unchanged.
- Single glitch: locked, din 10,11,99,13,14 → exactly one err pulse at the 99 sample, err_count=1, locked stays 1 (flywheel realigns at 13).
- Loss of lock: UNLOCK_N=3, locked, din frozen at 20 for 3 cycles → 3 err pulses, err_count+3, locked=0 after the third. Resuming din=21,22,… relocks after 5 samples.
- Saturation and clr: ERRCNT_W=2, 5 errors → err_count=3. clr coincident with an error → err=1, err_count=0.
- Async reset mid-lock: drop rst_n between edges → locked, err, err_count, expected = 0 immediately, without a clock edge. With COUNTER_CHECKER_SYNC_EN, repeat the clean-lock case: locked rises after edge 7.

Source files
------------

// File: rtl/counter_checker.sv
// counter_checker: locks onto an incrementing counter on din and flags/counts breaks in the sequence; define COUNTER_CHECKER_SYNC_EN to pass din through a 2-flop synchronizer
module counter_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 3,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [WIDTH-1:0]    din,
  output logic                locked,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [WIDTH-1:0]    expected
);
  localparam int MW = $clog2(LOCK_N + 1);
  localparam int NW = $clog2(UNLOCK_N + 1);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t          state;
  logic [MW-1:0]   match_cnt;
  logic [NW-1:0]   miss_cnt;
  logic [WIDTH-1:0] smp;
  logic            hit;
`ifdef COUNTER_CHECKER_SYNC_EN
  logic [WIDTH-1:0] sync_a;
  // two-flop synchronizer for sources not timed to clk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_a <= '0;
      smp    <= '0;
    end else begin
      sync_a <= din;
      smp    <= sync_a;
    end
`else
  assign smp = din;
`endif
  assign hit = smp == expected;
  // search/verify/locked sequencing with flywheel prediction once locked
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      err       <= 1'b0;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        SEARCH: begin
          expected  <= smp + 1'b1;
          match_cnt <= '0;
          state     <= VERIFY;
        end
        VERIFY:
          if (hit) begin
            expected  <= expected + 1'b1;
            match_cnt <= match_cnt + 1'b1;
            if (match_cnt + 1'b1 == MW'(LOCK_N)) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              miss_cnt <= '0;
            end
          end else begin
            expected  <= smp + 1'b1;
            match_cnt <= '0;
          end
        LOCKED: begin
          expected <= expected + 1'b1;
          if (hit) miss_cnt <= '0;
          else begin
            err      <= 1'b1;
            miss_cnt <= miss_cnt + 1'b1;
            if (miss_cnt + 1'b1 == NW'(UNLOCK_N)) begin
              state  <= SEARCH;
              locked <= 1'b0;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  // saturating error count; clr overrides a same-cycle error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_count <= '0;
    else if (clr) err_count <= '0;
    else if (state == LOCKED && !hit && err_count != '1) err_count <= err_count + 1'b1;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: randomized scoreboard bench for counter_checker against a sequence-rule model
module tb_counter_checker;
  localparam int W = 8, LN = 4, UN = 3, EW = 3;
  localparam int M = 1 << W;
  localparam int CMAX = (1 << EW) - 1;
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
  logic [W-1:0] din = '0;
  logic locked, err;
  logic [EW-1:0] err_count;
  logic [W-1:0] expected;
  always #5 clk = ~clk;
  counter_checker #(.WIDTH(W), .LOCK_N(LN), .UNLOCK_N(UN), .ERRCNT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din),
    .locked(locked), .err(err), .err_count(err_count), .expected(expected)
  );
  typedef struct {bit lk; bit er; int cnt; int ex;} resp_t;
  resp_t q[$];
  int n_cmp = 0, n_bad = 0;
  bit m_lk, m_have;
  int m_run, m_miss, m_exp, m_cnt;
  int hist[$];
  logic [W-1:0] v, g;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_lk = 0; m_have = 0; m_run = 0; m_miss = 0; m_exp = 0; m_cnt = 0;
    hist = {0, 0};
    q.delete();
  endtask
  task automatic model_step(input int d, input bit c);
    int s;
    bit e;
    resp_t r;
    e = 0;
`ifdef COUNTER_CHECKER_SYNC_EN
    hist.push_back(d);
    s = hist.pop_front();
`else
    s = d;
`endif
    if (m_lk) begin
      if (s != m_exp) begin
        e = 1;
        m_miss++;
        if (m_miss == UN) begin m_lk = 0; m_have = 0; end
      end else m_miss = 0;
      m_exp = (m_exp + 1) % M;
    end else if (!m_have) begin
      m_have = 1; m_run = 0; m_exp = (s + 1) % M;
    end else if (s == m_exp) begin
      m_run++;
      m_exp = (m_exp + 1) % M;
      if (m_run == LN) begin m_lk = 1; m_miss = 0; end
    end else begin
      m_run = 0; m_exp = (s + 1) % M;
    end
    m_cnt = c ? 0 : (e && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
    r.lk = m_lk; r.er = e; r.cnt = m_cnt; r.ex = m_exp;
    q.push_back(r);
  endtask
  task automatic step(input logic [W-1:0] d, input bit c);
    @(negedge clk);
    rst_n = 1'b1;
    din = d;
    clr = c;
    model_step(int'(d), c);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin step(v, 1'b0); v++; end
  endtask
  always @(posedge clk) begin
    resp_t r;
    #1;
    if (rst_n && q.size() > 0) begin
      r = q.pop_front();
      chk("locked", 32'(locked), 32'(r.lk));
      chk("err", 32'(err), 32'(r.er));
      chk("err_count", 32'(err_count), r.cnt);
      chk("expected", 32'(expected), r.ex);
    end
  end
  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #10;
    chk("reset_locked", 32'(locked), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_err_count", 32'(err_count), 0);
    chk("reset_expected", 32'(expected), 0);
    v = 8'd0;
    run(300);
    step(v, 1'b0); step(v + 8'd1, 1'b0); step(8'd99, 1'b0); step(v + 8'd3, 1'b0); step(v + 8'd4, 1'b0);
    v = v + 8'd5;
    run(3);
    repeat (4) step(v, 1'b0);
    v++;
    run(10);
    for (int i = 0; i < 9; i++) begin step(~v, 1'b0); v++; run(1); end
    step(~v, 1'b1); v++;
    run(3);
    step(~v, 1'b0); v++; step(~v, 1'b1); v++;
    run(6);
    for (int i = 0; i < 2000; i++) begin
      int r;
      bit c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 199) == 0);
      if (r < 4) begin g = 8'($urandom); step(g, c); v++; end
      else if (r < 6) repeat ($urandom_range(1, 5)) step(v, c);
      else if (r < 7) v = 8'($urandom);
      else begin step(v, c); v++; end
    end
    run(12);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_locked", 32'(locked), 0);
    chk("async_err", 32'(err), 0);
    chk("async_err_count", 32'(err_count), 0);
    chk("async_expected", 32'(expected), 0);
    @(posedge clk);
    for (int i = 0; i < 20; i++) step(8'd0, 1'b0);
    v = 8'd1;
    run(12);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
